// File: rtl/picorv32_ddr_bridge_if.sv
// PicoRV32 native memory bus plus single-word DDR request/response bus.
// The slave modport is the bridge; the master modport is the CPU/DDR environment around it.
interface picorv32_ddr_bridge_if #(
    parameter int DDR_ADDR_W = 16
);
    logic                  mem_valid;
    logic                  mem_instr;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;

    logic                  ddr_rd_req;
    logic                  ddr_wr_req;
    logic [DDR_ADDR_W-1:0] ddr_addr;
    logic [31:0]           ddr_wr_data;
    logic                  ddr_rd_valid;
    logic [31:0]           ddr_rd_data;
    logic                  ddr_wr_ack;

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  ddr_rd_valid, ddr_rd_data, ddr_wr_ack,
        output mem_ready, mem_rdata,
        output ddr_rd_req, ddr_wr_req, ddr_addr, ddr_wr_data
    );

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output ddr_rd_valid, ddr_rd_data, ddr_wr_ack,
        input  mem_ready, mem_rdata,
        input  ddr_rd_req, ddr_wr_req, ddr_addr, ddr_wr_data
    );
endinterface

// File: rtl/picorv32_ddr_bridge.sv
// PicoRV32 native bus to single-word DDR bridge with read-modify-write for partial stores.
// Optional wait-state watchdog enabled by defining DDR_BRIDGE_TIMEOUT_EN.
module picorv32_ddr_bridge #(
    parameter int DDR_ADDR_W     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 resetn,
    picorv32_ddr_bridge_if.slave bus,
    output logic                 bus_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_WR_WAIT,
        ST_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DDR_ADDR_W-1:0] r_ddr_addr;
    logic [DDR_ADDR_W-1:0] w_ddr_addr_nxt;
    logic [31:0]           r_ddr_wr_data;
    logic [31:0]           w_ddr_wr_data_nxt;
    logic [31:0]           r_mem_rdata;
    logic [31:0]           w_mem_rdata_nxt;
    logic [31:0]           r_wdata;
    logic [31:0]           w_wdata_nxt;
    logic [3:0]            r_wstrb;
    logic [3:0]            w_wstrb_nxt;
    logic                  r_mem_ready;
    logic                  w_mem_ready_nxt;
    logic                  r_rd_req;
    logic                  w_rd_req_nxt;
    logic                  r_wr_req;
    logic                  w_wr_req_nxt;
    logic                  r_bus_err;
    logic                  w_bus_err_nxt;

    logic                  w_accept;
    logic                  w_out_of_range;
    logic                  w_timeout;
    logic [31:0]           w_merged;
    logic                  w_unused;

    assign w_accept       = (r_state == ST_IDLE) && bus.mem_valid && !r_mem_ready;
    assign w_out_of_range = |bus.mem_addr[31:DDR_ADDR_W+2];

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned (latch).
    always_comb begin
        w_merged = bus.ddr_rd_data;
        for (int i = 0; i < 4; i++) begin
            if (r_wstrb[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
        end
    end

`ifdef DDR_BRIDGE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] r_timer;

    // Restarts on every state change, so each wait state gets the full budget.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if (w_state_nxt != r_state) begin
            r_timer <= '0;
        end else if (r_state == ST_RD_WAIT || r_state == ST_RMW_RD || r_state == ST_WR_WAIT) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    assign w_timeout = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_unused  = ^{bus.mem_instr, bus.mem_addr[1:0]};
`else
    assign w_timeout = 1'b0;
    assign w_unused  = ^{bus.mem_instr, bus.mem_addr[1:0], TIMEOUT_CYCLES[0]};
`endif

    // State and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_ddr_addr    <= '0;
            r_ddr_wr_data <= '0;
            r_mem_rdata   <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_mem_ready   <= 1'b0;
            r_rd_req      <= 1'b0;
            r_wr_req      <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ddr_addr    <= w_ddr_addr_nxt;
            r_ddr_wr_data <= w_ddr_wr_data_nxt;
            r_mem_rdata   <= w_mem_rdata_nxt;
            r_wdata       <= w_wdata_nxt;
            r_wstrb       <= w_wstrb_nxt;
            r_mem_ready   <= w_mem_ready_nxt;
            r_rd_req      <= w_rd_req_nxt;
            r_wr_req      <= w_wr_req_nxt;
            r_bus_err     <= w_bus_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_out_of_range)             w_state_nxt = ST_RESP;
                    else if (bus.mem_wstrb == 4'h0) w_state_nxt = ST_RD_WAIT;
                    else if (bus.mem_wstrb == 4'hF) w_state_nxt = ST_WR_WAIT;
                    else                            w_state_nxt = ST_RMW_RD;
                end
            end
            ST_RD_WAIT: if (bus.ddr_rd_valid || w_timeout) w_state_nxt = ST_RESP;
            ST_RMW_RD: begin
                if (bus.ddr_rd_valid)  w_state_nxt = ST_RMW_WR;
                else if (w_timeout)    w_state_nxt = ST_RESP;
            end
            ST_RMW_WR:  w_state_nxt = ST_WR_WAIT;
            ST_WR_WAIT: if (bus.ddr_wr_ack || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; a real response wins over a same-cycle timeout.
    always_comb begin
        w_ddr_addr_nxt    = r_ddr_addr;
        w_ddr_wr_data_nxt = r_ddr_wr_data;
        w_mem_rdata_nxt   = r_mem_rdata;
        w_wdata_nxt       = r_wdata;
        w_wstrb_nxt       = r_wstrb;
        w_mem_ready_nxt   = (w_state_nxt == ST_RESP);
        w_rd_req_nxt      = 1'b0;
        w_wr_req_nxt      = 1'b0;
        w_bus_err_nxt     = r_bus_err;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_ddr_addr_nxt  = bus.mem_addr[DDR_ADDR_W+1:2];
                    w_wdata_nxt     = bus.mem_wdata;
                    w_wstrb_nxt     = bus.mem_wstrb;
                    w_mem_rdata_nxt = '0;
                    if (w_out_of_range) begin
                        w_bus_err_nxt = 1'b1;
                    end else if (bus.mem_wstrb == 4'hF) begin
                        w_wr_req_nxt      = 1'b1;
                        w_ddr_wr_data_nxt = bus.mem_wdata;
                    end else begin
                        w_rd_req_nxt = 1'b1;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (bus.ddr_rd_valid) begin
                    w_mem_rdata_nxt = bus.ddr_rd_data;
                end else if (w_timeout) begin
                    w_mem_rdata_nxt = 32'hDEAD_BEEF;
                    w_bus_err_nxt   = 1'b1;
                end
            end
            ST_RMW_RD: begin
                if (bus.ddr_rd_valid) begin
                    w_ddr_wr_data_nxt = w_merged;
                    w_wr_req_nxt      = 1'b1;
                end else if (w_timeout) begin
                    w_mem_rdata_nxt = 32'hDEAD_BEEF;
                    w_bus_err_nxt   = 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (!bus.ddr_wr_ack && w_timeout) begin
                    w_mem_rdata_nxt = 32'hDEAD_BEEF;
                    w_bus_err_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_ready   = r_mem_ready;
    assign bus.mem_rdata   = r_mem_rdata;
    assign bus.ddr_rd_req  = r_rd_req;
    assign bus.ddr_wr_req  = r_wr_req;
    assign bus.ddr_addr    = r_ddr_addr;
    assign bus.ddr_wr_data = r_ddr_wr_data;
    assign bus_err         = r_bus_err;

endmodule

// File: tb/tb_picorv32_ddr_bridge.sv
// Scoreboard bench for picorv32_ddr_bridge: directed CPU accesses against a behavioural DDR model.
// Timeout scenarios run only when DDR_BRIDGE_TIMEOUT_EN is defined.
module tb_picorv32_ddr_bridge;

    localparam int AW = 16;
    localparam int TO = 10;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          lat_chk;
        int          gap;
    } resp_t;

    typedef struct {
        bit          is_wr;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } ddr_op_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic bus_err;

    resp_t   resp_q[$];
    ddr_op_t op_q[$];
    logic [31:0] ddr_mem [int unsigned];

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    int ddr_lat = 1;
    bit ddr_mute = 1'b0;
    int stray_reqs = 0;
    int stray_done = 0;
    bit stray_is_wr = 1'b0;

    always #5 clk = ~clk;

    picorv32_ddr_bridge_if #(.DDR_ADDR_W(AW)) bus ();

    picorv32_ddr_bridge #(
        .DDR_ADDR_W    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave),
        .bus_err(bus_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void exp_resp(input logic [31:0] rd, input logic err, input bit lat, input int gap);
        resp_q.push_back('{rd, err, lat, gap});
    endfunction

    function automatic void exp_op(input bit is_wr, input logic [AW-1:0] addr, input logic [31:0] data);
        op_q.push_back('{is_wr, addr, data});
    endfunction

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        return ddr_mem.exists(int'(a)) ? ddr_mem[int'(a)] : 32'h0;
    endfunction

    // Monitor: pops expectations whenever the DUT issues a DDR request or a CPU response.
    initial begin : monitor
        bit      prev_resp;
        bit      prev_ready;
        int      cyc;
        int      req_cyc;
        ddr_op_t op;
        resp_t   r;
        prev_resp = 1'b0;
        prev_ready = 1'b0;
        cyc = 0;
        req_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.ddr_rd_req || bus.ddr_wr_req) begin
                req_cyc = cyc;
                if (op_q.size() == 0) begin
                    check("ddr_unexpected_req", {62'd0, bus.ddr_rd_req, bus.ddr_wr_req}, 64'd0);
                end else begin
                    op = op_q.pop_front();
                    check("ddr_req_kind", {62'd0, bus.ddr_rd_req, bus.ddr_wr_req}, op.is_wr ? 64'd1 : 64'd2);
                    check("ddr_addr", 64'(bus.ddr_addr), 64'(op.addr));
                    if (op.is_wr) check("ddr_wr_data", 64'(bus.ddr_wr_data), 64'(op.data));
                end
            end
            if (bus.mem_ready) begin
                ready_cnt++;
                check("ready_pulse_width", 64'(prev_ready), 64'd0);
                if (resp_q.size() == 0) begin
                    check("unexpected_ready", 64'(bus.mem_ready), 64'd0);
                end else begin
                    r = resp_q.pop_front();
                    check("mem_rdata", 64'(bus.mem_rdata), 64'(r.rdata));
                    check("bus_err", 64'(bus_err), 64'(r.err));
                    if (r.lat_chk) check("resp_latency", 64'(prev_resp), 64'd1);
                    if (r.gap >= 0) check("timeout_gap", 64'(cyc - req_cyc), 64'(r.gap));
                end
            end
            prev_ready = bus.mem_ready;
            prev_resp  = bus.ddr_rd_valid || bus.ddr_wr_ack;
        end
    end

    // DDR model: answers one request at a time after ddr_lat extra cycles, or injects stray pulses.
    initial begin : ddr_model
        logic [AW-1:0] a;
        logic [31:0]   d;
        bus.ddr_rd_valid = 1'b0;
        bus.ddr_rd_data  = '0;
        bus.ddr_wr_ack   = 1'b0;
        forever begin
            @(negedge clk);
            if (stray_done != stray_reqs) begin
                @(posedge clk); #1;
                if (stray_is_wr) begin
                    bus.ddr_wr_ack = 1'b1;
                end else begin
                    bus.ddr_rd_data  = 32'h5555_AAAA;
                    bus.ddr_rd_valid = 1'b1;
                end
                @(posedge clk); #1;
                bus.ddr_rd_valid = 1'b0;
                bus.ddr_wr_ack   = 1'b0;
                stray_done++;
            end else if (!ddr_mute && bus.ddr_rd_req) begin
                a = bus.ddr_addr;
                repeat (ddr_lat) @(posedge clk);
                @(posedge clk); #1;
                bus.ddr_rd_data  = mem_rd(a);
                bus.ddr_rd_valid = 1'b1;
                @(posedge clk); #1;
                bus.ddr_rd_valid = 1'b0;
            end else if (!ddr_mute && bus.ddr_wr_req) begin
                a = bus.ddr_addr;
                d = bus.ddr_wr_data;
                repeat (ddr_lat) @(posedge clk);
                @(posedge clk); #1;
                check("ddr_hold", {16'd0, bus.ddr_addr, bus.ddr_wr_data}, {16'd0, a, d});
                ddr_mem[int'(a)] = d;
                bus.ddr_wr_ack = 1'b1;
                @(posedge clk); #1;
                bus.ddr_wr_ack = 1'b0;
            end
        end
    end

    task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_instr = (wstrb == 4'h0);
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        if (!hold) begin
            // Drop the request and scramble the bus once accepted; the bridge must have latched it.
            @(negedge clk);
            bus.mem_valid = 1'b0;
            bus.mem_addr  = 32'hFFFF_FFFF;
            bus.mem_wdata = 32'h0;
            bus.mem_wstrb = 4'h0;
        end
        while (!bus.mem_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cpu_wait_bound", 64'(bus.mem_ready), 64'd1);
        bus.mem_valid = 1'b0;
    endtask

    task automatic stray(input bit is_wr);
        int n;
        n = 0;
        stray_is_wr = is_wr;
        stray_reqs++;
        while (stray_done != stray_reqs && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stray_issued", 64'(stray_done), 64'(stray_reqs));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        int n0;
        int n;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        ddr_mem[5]     = 32'h1234_5678;
        ddr_mem[16'hFFFF] = 32'h0BAD_F00D;

        repeat (3) @(negedge clk);
        check("reset_ctrl", {60'd0, bus.mem_ready, bus.ddr_rd_req, bus.ddr_wr_req, bus_err}, 64'd0);
        check("reset_rdata_addr", {16'd0, bus.mem_rdata, bus.ddr_addr}, 64'd0);
        check("reset_wr_data", 64'(bus.ddr_wr_data), 64'd0);
        resetn = 1'b1;

        // Plain read of word 5.
        exp_op(1'b0, 16'd5, 32'h0); exp_resp(32'h1234_5678, 1'b0, 1'b1, -1);
        cpu_access(32'h0000_0014, 32'h0, 4'h0, 1'b1);

        // Full write then readback of word 8.
        exp_op(1'b1, 16'd8, 32'hCAFE_F00D); exp_resp(32'h0, 1'b0, 1'b1, -1);
        cpu_access(32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1'b1);
        exp_op(1'b0, 16'd8, 32'h0); exp_resp(32'hCAFE_F00D, 1'b0, 1'b1, -1);
        cpu_access(32'h0000_0020, 32'h0, 4'h0, 1'b1);

        // Read-modify-write of byte 1.
        exp_op(1'b0, 16'd8, 32'h0); exp_op(1'b1, 16'd8, 32'hCAFE_AB0D); exp_resp(32'h0, 1'b0, 1'b1, -1);
        cpu_access(32'h0000_0020, 32'h0000_AB00, 4'b0010, 1'b1);

        // RMW bytes 3 and 0, slow DDR, mem_valid dropped after acceptance.
        ddr_lat = 3;
        exp_op(1'b0, 16'd5, 32'h0); exp_op(1'b1, 16'd5, 32'hAA34_56DD); exp_resp(32'h0, 1'b0, 1'b1, -1);
        cpu_access(32'h0000_0014, 32'hAABB_CCDD, 4'b1001, 1'b0);
        ddr_lat = 1;

        // RMW middle bytes, then readback.
        exp_op(1'b0, 16'd5, 32'h0); exp_op(1'b1, 16'd5, 32'hAA22_33DD); exp_resp(32'h0, 1'b0, 1'b1, -1);
        cpu_access(32'h0000_0014, 32'h1122_3344, 4'b0110, 1'b1);
        exp_op(1'b0, 16'd5, 32'h0); exp_resp(32'hAA22_33DD, 1'b0, 1'b1, -1);
        cpu_access(32'h0000_0014, 32'h0, 4'h0, 1'b1);

        // Highest in-range word.
        exp_op(1'b0, 16'hFFFF, 32'h0); exp_resp(32'h0BAD_F00D, 1'b0, 1'b1, -1);
        cpu_access(32'h0003_FFFC, 32'h0, 4'h0, 1'b1);
        check("bus_err_clear", 64'(bus_err), 64'd0);

        // Unsolicited DDR responses while idle.
        n0 = ready_cnt;
        stray(1'b0);
        stray(1'b1);
        repeat (3) @(negedge clk);
        check("stray_idle", 64'(ready_cnt), 64'(n0));

        // Out-of-range read and write: no DDR traffic, bus_err sticky.
        exp_resp(32'h0, 1'b1, 1'b0, -1);
        cpu_access(32'h0004_0000, 32'h0, 4'h0, 1'b1);
        exp_resp(32'h0, 1'b1, 1'b0, -1);
        cpu_access(32'h8000_0014, 32'h5555_5555, 4'hF, 1'b1);
        repeat (2) @(negedge clk);
        check("bus_err_sticky", 64'(bus_err), 64'd1);

`ifdef DDR_BRIDGE_TIMEOUT_EN
        // Silent DDR: read and RMW both time out; the RMW write is never issued.
        ddr_mute = 1'b1;
        exp_op(1'b0, 16'd5, 32'h0); exp_resp(32'hDEAD_BEEF, 1'b1, 1'b0, TO);
        cpu_access(32'h0000_0014, 32'h0, 4'h0, 1'b1);
        ddr_mute = 1'b0;
        n0 = ready_cnt;
        stray(1'b0);
        repeat (3) @(negedge clk);
        check("late_rd_ignored", 64'(ready_cnt), 64'(n0));
        ddr_mute = 1'b1;
        exp_op(1'b0, 16'd5, 32'h0); exp_resp(32'hDEAD_BEEF, 1'b1, 1'b0, TO);
        cpu_access(32'h0000_0014, 32'hFFFF_FFFF, 4'b0001, 1'b1);
        repeat (3) @(negedge clk);
        check("rmw_timeout_no_write", 64'(op_q.size()), 64'd0);
        ddr_mute = 1'b0;
`endif

        // Reset while waiting in RMW_RD.
        ddr_mute = 1'b1;
        exp_op(1'b0, 16'd8, 32'h0);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0020;
        bus.mem_wdata = 32'h0000_0077;
        bus.mem_wstrb = 4'b0001;
        n = 0;
        while (!bus.ddr_rd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rmw_rd_issued", 64'(bus.ddr_rd_req), 64'd1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("abort_ctrl", {60'd0, bus.mem_ready, bus.ddr_rd_req, bus.ddr_wr_req, bus_err}, 64'd0);
        check("abort_rdata_addr", {16'd0, bus.mem_rdata, bus.ddr_addr}, 64'd0);
        check("abort_wr_data", 64'(bus.ddr_wr_data), 64'd0);
        bus.mem_valid = 1'b0;
        resp_q.delete();
        op_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        ddr_mute = 1'b0;

        n0 = ready_cnt;
        stray(1'b0);
        stray(1'b1);
        repeat (3) @(negedge clk);
        check("stray_after_reset", 64'(ready_cnt), 64'(n0));

        // Word 8 untouched by the abandoned RMW.
        exp_op(1'b0, 16'd8, 32'h0); exp_resp(32'hCAFE_AB0D, 1'b0, 1'b1, -1);
        cpu_access(32'h0000_0020, 32'h0, 4'h0, 1'b1);

        repeat (4) @(negedge clk);
        check("queues_drained", 64'(resp_q.size() + op_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
